// File: rtl/pipe_pkg.sv
// Shared definitions for the RV inter-stage pipeline registers.
//   - Payload widths of the standard stage bundles.
//   - Bit offsets of the fields inside the MEM/WB bundle.
//   - Debug encoding of the skid-stage occupancy (EMPTY / ONE / TWO).
//   - Helper that packs a MEM/WB bundle from its fields.
package pipe_pkg;

  // MEM/WB: regWrite, memToReg, readData[31:0], aluResult[31:0], writeReg[4:0]
  localparam int MEMWB_W = 1 + 1 + 32 + 32 + 5;
  // EX/MEM: regWrite, memToReg, memRead, memWrite, aluResult, writeData, writeReg
  localparam int EXMEM_W = 1 + 1 + 1 + 1 + 32 + 32 + 5;

  localparam int REGWRITE_BIT  = 70;
  localparam int MEMTOREG_BIT  = 69;
  localparam int READDATA_LSB  = 37;
  localparam int ALURESULT_LSB = 5;
  localparam int WRITEREG_LSB  = 0;

  // Occupancy of a skid stage, exposed on the debug output.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  function automatic logic [MEMWB_W-1:0] pack_memwb(
    input logic        reg_write,
    input logic        mem_to_reg,
    input logic [31:0] read_data,
    input logic [31:0] alu_result,
    input logic [4:0]  write_reg
  );
    logic [MEMWB_W-1:0] b;
    b = '0;
    b[REGWRITE_BIT]                    = reg_write;
    b[MEMTOREG_BIT]                    = mem_to_reg;
    b[READDATA_LSB  +: 32]             = read_data;
    b[ALURESULT_LSB +: 32]             = alu_result;
    b[WRITEREG_LSB  +: 5]              = write_reg;
    return b;
  endfunction

endpackage

// File: rtl/sat_counter_rv.sv
// Saturating up-counter for performance monitoring.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset (count -> 0)
//   clr     - synchronous clear, wins over inc
//   inc     - count one event this cycle
//   count   - current value, sticks at all-ones
module sat_counter_rv #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid_rv.sv
// Inter-stage pipeline register with a 2-entry skid buffer.
// Ports:
//   clock, reset_n          - rising-edge clock, asynchronous active-low reset
//   flush                   - synchronous squash of held and incoming beats
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and payload
//   cnt_clr                 - synchronous clear of stall_count
//   stall_count             - saturating count of cycles out_valid & !out_ready
//   state_dbg               - occupancy (ST_EMPTY / ST_ONE / ST_TWO)
//
// Handshake: a beat moves when valid & ready are both high at a rising edge.
// A producer keeps valid and data stable until the beat moves; ready never
// depends combinationally on valid. Here in_ready comes straight from the
// skid flop, so downstream back-pressure never reaches upstream in the same
// cycle -- the skid entry absorbs the one beat already in flight.
module pipe_stage_skid_rv
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 71,
  parameter int CNT_W    = 16,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_count,
  output logic [1:0]        state_dbg
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_fire;
  logic out_fire;

  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_v_q && out_ready;

  assign state_dbg = !main_v_q ? ST_EMPTY : (skid_v_q ? ST_TWO : ST_ONE);

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;

    if (!main_v_q) begin
      // EMPTY
      if (in_fire) begin
        main_v_d    = 1'b1;
        main_data_d = in_data;
      end
    end else if (!skid_v_q) begin
      // ONE
      if (in_fire && out_fire) begin
        main_data_d = in_data;
      end else if (in_fire) begin
        skid_v_d    = 1'b1;
        skid_data_d = in_data;
      end else if (out_fire) begin
        main_v_d = 1'b0;
      end
    end else begin
      // TWO: in_ready is low, only the downstream side can move
      if (out_fire) begin
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end
    end

    // Flush overrides everything above. A beat leaving via out_fire this
    // cycle has already been seen downstream, so dropping it here is correct.
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (CLR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  sat_counter_rv #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (main_v_q && !out_ready),
    .count   (stall_count)
  );

  // The skid entry only fills behind a held main entry.
  a_no_skid_without_main: assert property (
    @(posedge clock) disable iff (!reset_n) !(!main_v_q && skid_v_q)
  );

endmodule

// File: tb/tb_pipe_stage_skid_rv.sv
module tb_pipe_stage_skid_rv;
  import pipe_pkg::*;

  localparam int DW  = 16;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          cnt_clr;
  logic [CW-1:0] stall_count;
  logic [1:0]    state_dbg;

  pipe_stage_skid_rv #(
    .DATA_W   (DW),
    .CNT_W    (CW),
    .CLR_DATA (1'b0)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .cnt_clr     (cnt_clr),
    .stall_count (stall_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  // The stage behaves as a 2-deep FIFO: the queue holds the beats it owns,
  // head first. Outputs follow directly from the queue contents.
  logic [DW-1:0] exp_q[$];
  int            stall_m = 0;
  int            n_cmp   = 0;
  int            n_err   = 0;
  bit            chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      stall_m = 0;
    end else begin
      bit m_in_fire;
      bit m_out_fire;
      m_in_fire  = in_valid && (exp_q.size() < 2);
      m_out_fire = (exp_q.size() > 0) && out_ready;
      if (cnt_clr) stall_m = 0;
      else if ((exp_q.size() > 0) && !out_ready && (stall_m < SAT)) stall_m++;
      if (m_out_fire) void'(exp_q.pop_front());
      if (m_in_fire) exp_q.push_back(in_data);
      if (flush) exp_q.delete();
    end
  end

  always @(negedge clock) begin
    if (chk_en && reset_n) begin
      int sz;
      sz = exp_q.size();
      chk("model_out_valid", 32'(out_valid), 32'(sz > 0));
      chk("model_in_ready", 32'(in_ready), 32'(sz < 2));
      if (sz > 0) chk("model_out_data", 32'(out_data), 32'(exp_q[0]));
      chk("model_stall_count", 32'(stall_count), 32'(stall_m));
      chk("model_state", 32'(state_dbg),
          32'((sz == 0) ? ST_EMPTY : ((sz == 1) ? ST_ONE : ST_TWO)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    step();

    // Streaming 1,2,3 with out_ready high: latency 1, full rate.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'd1; step();
    chk("stream_v1", 32'(out_valid), 32'd1);
    chk("stream_d1", 32'(out_data), 32'd1);
    in_data = 16'd2; step();
    chk("stream_d2", 32'(out_data), 32'd2);
    chk("stream_rdy", 32'(in_ready), 32'd1);
    in_data = 16'd3; step();
    chk("stream_d3", 32'(out_data), 32'd3);
    in_valid = 1'b0; step();
    chk("stream_drain", 32'(out_valid), 32'd0);
    chk("stream_stall", 32'(stall_count), 32'd0);

    // Back-pressure: A then B fill both entries.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b0;
    push(16'h000A);
    chk("bp_a_data", 32'(out_data), 32'h0A);
    chk("bp_a_rdy", 32'(in_ready), 32'd1);
    chk("bp_a_stall", 32'(stall_count), 32'd0);
    push(16'h000B);
    chk("bp_b_rdy", 32'(in_ready), 32'd0);
    chk("bp_b_data", 32'(out_data), 32'h0A);
    chk("bp_b_stall", 32'(stall_count), 32'd1);
    step();
    chk("bp_hold_stall", 32'(stall_count), 32'd2);
    out_ready = 1'b1;
    chk("bp_rel_a", 32'(out_data), 32'h0A);
    step();
    chk("bp_rel_b", 32'(out_data), 32'h0B);
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    step();
    chk("bp_rel_empty", 32'(out_valid), 32'd0);
    chk("bp_rel_stall", 32'(stall_count), 32'd2);

    // Flush while full, with a beat offered in the same cycle.
    out_ready = 1'b0;
    push(16'h0011);
    push(16'h0022);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h000C;
    step();
    idle();
    chk("flush2_valid", 32'(out_valid), 32'd0);
    chk("flush2_rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step(3);
    chk("flush2_no_c", 32'(out_valid), 32'd0);

    // Flush in ONE while a new beat is accepted: the new beat is discarded.
    out_ready = 1'b0;
    push(16'h000D);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h000C;
    step();
    idle();
    chk("flush1_valid", 32'(out_valid), 32'd0);
    step();
    chk("flush1_no_c", 32'(out_valid), 32'd0);

    // Flush with out_ready high: 0x5 is delivered in the flush cycle.
    push(16'h0005);
    flush = 1'b1; out_ready = 1'b1;
    chk("flush_dlv_v", 32'(out_valid), 32'd1);
    chk("flush_dlv_d", 32'(out_data), 32'h05);
    step();
    idle();
    chk("flush_dlv_after", 32'(out_valid), 32'd0);
    step();
    chk("flush_dlv_none", 32'(out_valid), 32'd0);

    // Stall counter saturation and clear priority.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b0;
    push(16'h0009);
    step(20);
    chk("sat_15", 32'(stall_count), 32'd15);
    cnt_clr = 1'b1; step();
    chk("sat_clr", 32'(stall_count), 32'd0);
    cnt_clr = 1'b0; step();
    chk("sat_restart", 32'(stall_count), 32'd1);

    // Asynchronous reset mid-cycle while full.
    push(16'h0033);
    chk("ar_full", 32'(in_ready), 32'd0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_stall", 32'(stall_count), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    push(16'h0007);
    chk("ar_first_v", 32'(out_valid), 32'd1);
    chk("ar_first_d", 32'(out_data), 32'h07);
    step();

    // Random traffic checked cycle by cycle against the queue model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom_range(0, 65535));
      out_ready = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 24) == 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      step();
    end
    idle();
    out_ready = 1'b1;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_rv.md
Name: pipe_stage_skid_rv

Overview:
- Generalised inter-stage pipeline register for the RV pipeline (EX/MEM, MEM/WB and later stages).
- Replaces free-running capture registers with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never creates a combinational ready path across stages.
- Adds synchronous flush (squash) and a saturating stall-cycle counter for performance monitoring.
- Payload is an opaque DATA_W bus. The instantiating stage packs control bits (registerWrite, memoryToRegister, …) and data (ALU result, read data, destination register) into it.

Parameters:
- DATA_W, 71, payload width in bits (default = 1+1+32+32+5, the MEM/WB bundle).
- CNT_W, 16, width of the stall-cycle counter.
- CLR_DATA, 0, if 1 then flush also zeroes the data registers; if 0 only the valid bits are cleared.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all held and incoming beats.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept; registered (no combinational path from out_ready).
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  downstream payload, straight from the main register.
- cnt_clr  input  1  synchronous clear of stall_count.
- stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d).
- out_valid=main_v; out_data=main_d; in_ready=!skid_v (registered via skid_v).
- in_fire=in_valid&in_ready; out_fire=out_valid&out_ready.
- Reset (reset_n=0, asynchronous): main_v=0, skid_v=0, main_d=0, skid_d=0, stall_count=0. After reset: in_ready=1, out_valid=0.
- States (derived): EMPTY (main_v=0), ONE (main_v=1, skid_v=0), TWO (main_v=1, skid_v=1). The state main_v=0 with skid_v=1 is illegal and must be covered by an assertion.
- EMPTY: in_fire -> ONE, main_d<=in_data; otherwise stay.
- ONE, in_fire & out_fire -> ONE, main_d<=in_data.
- ONE, in_fire & !out_ready -> TWO, skid_d<=in_data.
- ONE, !in_fire & out_fire -> EMPTY.
- ONE, neither -> hold.
- TWO: in_ready=0. out_fire -> ONE, main_d<=skid_d, skid_v<=0. Otherwise hold.
- Latency: in_fire in cycle N -> out_valid=1 in cycle N+1 with that data (from EMPTY, or from ONE with simultaneous out_fire).
- Throughput: 1 beat/cycle sustained when out_ready=1.
- Ordering: strict FIFO; no beat is dropped or duplicated except by flush.
- Flush (highest priority):
  - next state EMPTY (main_v<=0, skid_v<=0).
  - A beat accepted by in_fire in the flush cycle is discarded.
  - A beat leaving via out_fire in the flush cycle is counted as delivered; downstream sees it in that cycle.
  - If CLR_DATA=1, main_d and skid_d <= 0.
- Stall counter:
  - Increments each cycle out_valid & !out_ready, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr has priority over increment and loads 0.
  - flush does not affect the counter.
- Reset asserted mid-transfer: all beats lost immediately; in_ready goes to 1 asynchronously.
- No X on outputs after reset regardless of inputs.

Decomposition:
- Shared package pipe_pkg:
  - localparams MEMWB_W=71, EXMEM_W.
  - Field-offset constants for the MEM/WB bundle: REGWRITE_BIT=70, MEMTOREG_BIT=69, READDATA_LSB=37, ALURESULT_LSB=5, WRITEREG_LSB=0.
- One natural sub-module: sat_counter_rv (parameter W; ports clock, reset_n, clr, inc, count), reused for other performance counters.

Test Plan:
- Reset, then hold out_ready=1 and stream in_data=1,2,3 on consecutive cycles -> out_data=1,2,3 one cycle later each; in_ready stays 1; stall_count=0.
- Push 0xA then 0xB with out_ready=0 -> in_ready=0 after the second beat; out_data=0xA; stall_count increments each held cycle. Raise out_ready -> 0xA then 0xB emerge, in_ready returns to 1.
- Flush while in TWO, with in_valid=1 and data 0xC in the same cycle -> next cycle out_valid=0, in_ready=1; 0xC is never seen at the output.
- Flush with out_ready=1 and main holding 0x5 -> 0x5 is delivered in the flush cycle; nothing follows it.
- CNT_W=4, hold out_ready=0 with a valid beat for 20 cycles -> stall_count=15 (saturated). Pulse cnt_clr together with a stall -> stall_count=0.
- Assert reset_n=0 asynchronously mid-cycle while in TWO -> out_valid=0, in_ready=1 immediately. After release, the first accepted beat 0x7 appears with latency 1.
